cp0_ext: RTL and testbench

Parametrised coprocessor-0 for the pipelined MIPS core. It is the successor to the fixed 6-line CP0. It adds a configurable hardware-interrupt width, an internal Count/Compare timer that raises its own interrupt line, a BadVAddr register, and a read-only PRId. It sits beside the M stage. It takes the victim instruction's PC, BD flag and exception code, drives `Req` to redirect fetch to the handler, and serves `mfc0`/`mtc0`/`eret`.

---
 rtl/cp0_ext_pkg.sv | 22 ++
 rtl/cp0_ext_timer.sv | 47 ++++
 rtl/cp0_ext.sv | 115 +++++++++++
 tb/tb_cp0_ext.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_ext_pkg.sv
// Shared CP0 constants: register addresses and exception codes.
package cp0_ext_pkg;

   localparam logic [4:0] ADDR_BADVA   = 5'd8;
   localparam logic [4:0] ADDR_COUNT   = 5'd9;
   localparam logic [4:0] ADDR_COMPARE = 5'd11;
   localparam logic [4:0] ADDR_SR      = 5'd12;
   localparam logic [4:0] ADDR_CAUSE   = 5'd13;
   localparam logic [4:0] ADDR_EPC     = 5'd14;
   localparam logic [4:0] ADDR_PRID    = 5'd15;

   localparam logic [4:0] EXCCODE_INT  = 5'd0;
   localparam logic [4:0] EXCCODE_ADEL = 5'd4;
   localparam logic [4:0] EXCCODE_ADES = 5'd5;
   // Not a real MIPS code; reserved here to mean "no exception this cycle".
   localparam logic [4:0] NO_EXCCODE   = 5'd31;

   function automatic logic is_addr_err(input logic [4:0] code);
      return (code == EXCCODE_ADEL) || (code == EXCCODE_ADES);
   endfunction

endpackage

// File: rtl/cp0_ext_timer.sv
// Count/Compare timer: prescaled free-running Count, Compare match sets a sticky TI.
module cp0_timer #(
   parameter int CNT_DIV = 1
) (
   input  logic        clk,
   input  logic        RESET,
   input  logic        wr_count,
   input  logic        wr_compare,
   input  logic [31:0] D,
   output logic [31:0] count,
   output logic [31:0] compare,
   output logic        ti
);

   localparam logic [7:0] PS_MAX = 8'(CNT_DIV - 1);

   logic [7:0] prescale;

   always_ff @(posedge clk) begin
      if (RESET) begin
         prescale <= '0;
         count    <= '0;
         compare  <= '0;
         ti       <= 1'b0;
      end else begin
         if (wr_count) begin
            count    <= D;
            prescale <= '0;
         end else if (prescale == PS_MAX) begin
            count    <= count + 32'd1;
            prescale <= '0;
         end else begin
            prescale <= prescale + 8'd1;
         end

         if (wr_compare)
            compare <= D;

         // A Compare write acknowledges the interrupt even on a coincident match.
         if (wr_compare)
            ti <= 1'b0;
         else if (count == compare)
            ti <= 1'b1;
      end
   end

endmodule

// File: rtl/cp0_ext.sv
// Coprocessor 0 beside the M stage: exception entry, mfc0/mtc0/eret, interrupt masking.
// Req, Q and Q_EPC are combinational; all state moves on the rising clk edge.
module cp0_ext
   import cp0_ext_pkg::*;
#(
   parameter int          N_HWINT    = 6,
   parameter int          TIMER_LINE = N_HWINT,
   parameter int          CNT_DIV    = 1,
   parameter logic [31:0] PRID       = 32'h0000_4200
) (
   input  logic               clk,
   input  logic               RESET,
   input  logic               WE,
   input  logic [4:0]         A,
   input  logic [31:0]        D,
   input  logic               D_BD,
   input  logic [31:0]        D_VPC,
   input  logic [4:0]         D_ExcCode,
   input  logic [31:0]        D_BadVA,
   input  logic [N_HWINT-1:0] D_HWInt,
   input  logic               EXL_CLR,
   output logic               Req,
   output logic [31:0]        Q,
   output logic [31:0]        Q_EPC,
   output logic               Q_EXL,
   output logic               Q_TI
);

   logic [7:0]  im, ip, int_vec;
   logic        exl, ie, bd;
   logic [4:0]  exc_code, new_exc;
   logic [31:0] epc, badva, count, compare;
   logic        ti, req_int, wr_en, wr_count, wr_compare;

   always_comb begin
      int_vec                 = '0;
      int_vec[N_HWINT-1:0]    = D_HWInt;
      int_vec[TIMER_LINE]     = int_vec[TIMER_LINE] | ti;
   end

   assign req_int    = |(int_vec & im);
   assign Req        = (~exl & ie & req_int) | (D_ExcCode != NO_EXCCODE);
   assign new_exc    = req_int ? EXCCODE_INT : D_ExcCode;

   // Exception entry and eret both squash any mtc0 in the same cycle.
   assign wr_en      = WE & ~Req & ~EXL_CLR;
   assign wr_count   = wr_en && (A == ADDR_COUNT);
   assign wr_compare = wr_en && (A == ADDR_COMPARE);

   cp0_timer #(.CNT_DIV(CNT_DIV)) u_timer (
      .clk        (clk),
      .RESET      (RESET),
      .wr_count   (wr_count),
      .wr_compare (wr_compare),
      .D          (D),
      .count      (count),
      .compare    (compare),
      .ti         (ti)
   );

   always_ff @(posedge clk) begin
      if (RESET) begin
         im       <= '0;
         ip       <= '0;
         exl      <= 1'b0;
         ie       <= 1'b0;
         bd       <= 1'b0;
         exc_code <= '0;
         epc      <= '0;
         badva    <= '0;
      end else begin
         ip <= int_vec;
         if (Req) begin
            exl      <= 1'b1;
            bd       <= D_BD;
            exc_code <= new_exc;
            epc      <= D_BD ? D_VPC - 32'd4 : D_VPC;
            if (is_addr_err(new_exc))
               badva <= D_BadVA;
         end else if (EXL_CLR) begin
            exl <= 1'b0;
         end else if (WE) begin
            case (A)
               ADDR_SR: begin
                  im  <= D[17:10];
                  exl <= D[1];
                  ie  <= D[0];
               end
               ADDR_EPC: epc <= D;
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      Q = '0;
      case (A)
         ADDR_BADVA:   Q = badva;
         ADDR_COUNT:   Q = count;
         ADDR_COMPARE: Q = compare;
         ADDR_SR:      Q = {14'b0, im, 8'b0, exl, ie};
         ADDR_CAUSE:   Q = {bd, ti, 12'b0, ip, 3'b0, exc_code, 2'b0};
         ADDR_EPC:     Q = epc;
         ADDR_PRID:    Q = PRID;
         default:      Q = '0;
      endcase
   end

   // eret reads EPC through here, so a same-cycle mtc0 EPC must be visible.
   assign Q_EPC = (WE && A == ADDR_EPC) ? D : epc;
   assign Q_EXL = exl;
   assign Q_TI  = ti;

endmodule

// File: tb/tb_cp0_ext.sv
// Bench for cp0_ext: directed vector table, timer sequence, then random traffic vs a reference model.
module tb_cp0_ext;
   import cp0_ext_pkg::*;

   localparam int N_HW = 6;
   localparam int TL   = 6;
   localparam int DIV  = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        we, d_bd, exl_clr;
   logic [4:0]  a, d_exc;
   logic [31:0] d, d_vpc, d_bva;
   logic [5:0]  d_hw;
   logic        req, q_exl, q_ti;
   logic [31:0] q, q_epc;

   int n_tests = 0;
   int n_fail  = 0;

   cp0_ext #(.N_HWINT(N_HW), .TIMER_LINE(TL), .CNT_DIV(DIV), .PRID(32'h0000_4200)) dut (
      .clk(clk), .RESET(rst), .WE(we), .A(a), .D(d), .D_BD(d_bd), .D_VPC(d_vpc),
      .D_ExcCode(d_exc), .D_BadVA(d_bva), .D_HWInt(d_hw), .EXL_CLR(exl_clr),
      .Req(req), .Q(q), .Q_EPC(q_epc), .Q_EXL(q_exl), .Q_TI(q_ti)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Reference model state, kept as plain architectural fields.
   logic [7:0]      m_im, m_ip;
   logic            m_exl, m_ie, m_bd, m_ti;
   logic [4:0]      m_exc;
   logic [31:0]     m_epc, m_badva, m_compare, m_load;
   longint unsigned m_elapsed;

   function automatic logic [31:0] m_count();
      return m_load + 32'(m_elapsed / DIV);
   endfunction

   typedef struct {
      logic        we;
      logic [4:0]  a;
      logic [31:0] d;
      logic [5:0]  hw;
      logic [4:0]  exc;
      logic        bd;
      logic [31:0] vpc;
      logic [31:0] bva;
      logic        eret;
      logic        e_req;
      logic [31:0] e_q;
      logic [31:0] e_epc;
      logic        e_exl;
   } vec_t;

   vec_t tab[19];

   function automatic vec_t mk(input logic w, input logic [4:0] ad, input logic [31:0] dd,
                               input logic [5:0] hw, input logic [4:0] ex, input logic b,
                               input logic [31:0] vp, input logic [31:0] bv, input logic er,
                               input logic rq, input logic [31:0] eq, input logic [31:0] ee,
                               input logic ex1);
      vec_t v;
      v.we = w; v.a = ad; v.d = dd; v.hw = hw; v.exc = ex; v.bd = b; v.vpc = vp; v.bva = bv;
      v.eret = er; v.e_req = rq; v.e_q = eq; v.e_epc = ee; v.e_exl = ex1;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle();
      we = 1'b0; a = 5'd0; d = '0; d_hw = '0; d_exc = NO_EXCCODE;
      d_bd = 1'b0; d_vpc = '0; d_bva = '0; exl_clr = 1'b0;
   endtask

   task automatic model_reset();
      m_im = '0; m_ip = '0; m_exl = 1'b0; m_ie = 1'b0; m_bd = 1'b0; m_ti = 1'b0;
      m_exc = '0; m_epc = '0; m_badva = '0; m_compare = '0; m_load = '0; m_elapsed = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   // One clock cycle: check outputs mid-cycle against the model (and table row), then advance.
   task automatic step(input int row);
      logic [7:0]  iv;
      logic        ri, mreq, wr;
      logic [31:0] mq, mepc, cnt;
      logic [4:0]  nexc;
      @(negedge clk);
      cnt = m_count();
      iv = '0;
      for (int k = 0; k < N_HW; k++) iv[k] = d_hw[k];
      if (m_ti) iv[TL] = 1'b1;
      ri   = |(iv & m_im);
      mreq = (!m_exl && m_ie && ri) || (d_exc != NO_EXCCODE);
      case (a)
         5'd8:    mq = m_badva;
         5'd9:    mq = cnt;
         5'd11:   mq = m_compare;
         5'd12:   mq = (32'(m_im) << 10) | (32'(m_exl) << 1) | 32'(m_ie);
         5'd13:   mq = (32'(m_bd) << 31) | (32'(m_ti) << 30) | (32'(m_ip) << 10) | (32'(m_exc) << 2);
         5'd14:   mq = m_epc;
         5'd15:   mq = 32'h0000_4200;
         default: mq = '0;
      endcase
      mepc = (we && a == 5'd14) ? d : m_epc;
      check("req",   32'(req),   32'(mreq));
      check("q",     q,          mq);
      check("q_epc", q_epc,      mepc);
      check("q_exl", 32'(q_exl), 32'(m_exl));
      check("q_ti",  32'(q_ti),  32'(m_ti));
      if (row >= 0) begin
         check($sformatf("row%0d_req", row), 32'(req),   32'(tab[row].e_req));
         check($sformatf("row%0d_q", row),   q,          tab[row].e_q);
         check($sformatf("row%0d_epc", row), q_epc,      tab[row].e_epc);
         check($sformatf("row%0d_exl", row), 32'(q_exl), 32'(tab[row].e_exl));
      end
      @(posedge clk);
      wr = !mreq && !exl_clr && we;
      if (wr && a == 5'd11) m_ti = 1'b0;
      else if (cnt == m_compare) m_ti = 1'b1;
      if (wr && a == 5'd9) begin
         m_load = d; m_elapsed = 0;
      end else begin
         m_elapsed++;
      end
      if (wr && a == 5'd11) m_compare = d;
      m_ip = iv;
      if (mreq) begin
         nexc  = ri ? 5'd0 : d_exc;
         m_exl = 1'b1;
         m_bd  = d_bd;
         m_exc = nexc;
         m_epc = d_bd ? d_vpc - 32'd4 : d_vpc;
         if (nexc == 5'd4 || nexc == 5'd5) m_badva = d_bva;
      end else if (exl_clr) begin
         m_exl = 1'b0;
      end else if (we) begin
         if (a == 5'd12) begin
            m_im = d[17:10]; m_exl = d[1]; m_ie = d[0];
         end else if (a == 5'd14) begin
            m_epc = d;
         end
      end
      #1;
   endtask

   initial begin
      int edges;
      int r;
      localparam logic [4:0] NO = NO_EXCCODE;
      //             we    a      d              hw    exc    bd    vpc            bva            eret  | req   q              epc            exl
      tab[0]  = mk(1'b0, 5'd13, 32'h0,         6'h0, NO,    1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0,         32'h0,         1'b0);
      tab[1]  = mk(1'b0, 5'd12, 32'h0,         6'h0, NO,    1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0,         32'h0,         1'b0);
      tab[2]  = mk(1'b0, 5'd14, 32'h0,         6'h0, NO,    1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0,         32'h0,         1'b0);
      tab[3]  = mk(1'b0, 5'd9,  32'h0,         6'h0, NO,    1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0,         32'h0,         1'b0);
      tab[4]  = mk(1'b0, 5'd11, 32'h0,         6'h0, NO,    1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0,         32'h0,         1'b0);
      tab[5]  = mk(1'b0, 5'd15, 32'h0,         6'h0, NO,    1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0000_4200, 32'h0,         1'b0);
      tab[6]  = mk(1'b1, 5'd11, 32'hFFFF_0000, 6'h0, NO,    1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0,         32'h0,         1'b0);
      tab[7]  = mk(1'b1, 5'd12, 32'h0000_0401, 6'h0, NO,    1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0,         32'h0,         1'b0);
      tab[8]  = mk(1'b0, 5'd12, 32'h0,         6'h1, NO,    1'b0, 32'h2000,      32'h0,         1'b0, 1'b1, 32'h0000_0401, 32'h0,         1'b0);
      tab[9]  = mk(1'b0, 5'd13, 32'h0,         6'h1, NO,    1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0000_0400, 32'h2000,      1'b1);
      tab[10] = mk(1'b0, 5'd13, 32'h0,         6'h0, 5'd5,  1'b1, 32'h3008,      32'h1235,      1'b0, 1'b1, 32'h0000_0400, 32'h2000,      1'b1);
      tab[11] = mk(1'b0, 5'd13, 32'h0,         6'h0, NO,    1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 32'h8000_0014, 32'h3004,      1'b1);
      tab[12] = mk(1'b0, 5'd8,  32'h0,         6'h0, NO,    1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 32'h1235,      32'h3004,      1'b1);
      tab[13] = mk(1'b1, 5'd14, 32'h4000,      6'h0, NO,    1'b0, 32'h0,         32'h0,         1'b1, 1'b0, 32'h3004,      32'h4000,      1'b1);
      tab[14] = mk(1'b0, 5'd14, 32'h0,         6'h0, NO,    1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 32'h3004,      32'h3004,      1'b0);
      tab[15] = mk(1'b1, 5'd14, 32'h5000,      6'h0, 5'd4,  1'b0, 32'h5550,      32'hBAD0,      1'b0, 1'b1, 32'h3004,      32'h5000,      1'b0);
      tab[16] = mk(1'b1, 5'd9,  32'h77,        6'h0, 5'd4,  1'b0, 32'h5550,      32'hBAD0,      1'b0, 1'b1, 32'h4,         32'h5550,      1'b1);
      tab[17] = mk(1'b0, 5'd14, 32'h0,         6'h0, NO,    1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 32'h5550,      32'h5550,      1'b1);
      tab[18] = mk(1'b0, 5'd9,  32'h0,         6'h0, NO,    1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 32'h4,         32'h5550,      1'b1);

      do_reset();
      for (int i = 0; i < 19; i++) begin
         we = tab[i].we; a = tab[i].a; d = tab[i].d; d_hw = tab[i].hw; d_exc = tab[i].exc;
         d_bd = tab[i].bd; d_vpc = tab[i].vpc; d_bva = tab[i].bva; exl_clr = tab[i].eret;
         step(i);
      end

      // Timer: eret, enable IM[TL]+IE, Count<-0, Compare<-3, then wait for TI.
      idle(); exl_clr = 1'b1;                        step(-1);
      idle(); we = 1'b1; a = 5'd12; d = 32'h0001_0001; step(-1);
      idle(); we = 1'b1; a = 5'd9;  d = 32'h0;         step(-1);
      idle(); we = 1'b1; a = 5'd11; d = 32'h3;         step(-1);
      idle();
      edges = 1;
      while (!q_ti && edges < 40) begin
         step(-1);
         edges++;
      end
      check("ti_latency", 32'(edges), 32'd13);
      check("timer_req", 32'(req), 32'd1);
      step(-1);
      check("timer_exl", 32'(q_exl), 32'd1);
      we = 1'b1; a = 5'd11; d = 32'h100; step(-1);
      idle();
      check("ti_cleared", 32'(q_ti), 32'd0);
      step(-1);

      // Randomized traffic against the model.
      do_reset();
      for (int n = 0; n < 1500; n++) begin
         idle();
         r  = $urandom_range(0, 9);
         case (r)
            0: a = 5'd8;  1: a = 5'd9;  2: a = 5'd11; 3: a = 5'd12;
            4: a = 5'd13; 5: a = 5'd14; 6: a = 5'd15; default: a = 5'($urandom_range(0, 31));
         endcase
         we = ($urandom_range(0, 2) == 0);
         d  = (a == 5'd9 || a == 5'd11) ? 32'($urandom_range(0, 24)) : $urandom;
         d_hw = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h0;
         r  = $urandom_range(0, 15);
         if (r == 12) d_exc = 5'd4;
         else if (r == 13) d_exc = 5'd5;
         else if (r == 14) d_exc = 5'd8;
         else if (r == 15) d_exc = 5'd12;
         d_bd    = 1'($urandom);
         d_vpc   = $urandom;
         d_bva   = $urandom;
         exl_clr = ($urandom_range(0, 7) == 0);
         step(-1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
